multdiv_unit: RTL and testbench
===============================

Name: multdiv_unit

Overview:
Iterative 32-bit signed multiply/divide unit in the execute stage, beside the ALU. It takes the same operand latches as the ALU. The pipeline stalls while it is busy, and its result joins the ALU result at the writeback select. It is a radix-2 shift-add multiplier and a restoring divider that share one 64-bit working register, with fixed latency for both operations.

Parameters:
WIDTH, 32, operand/result width; only 32 is supported and verified.
ITERS, 32, iteration count per operation; must equal WIDTH.

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous active-high reset
data_operandA  input  32  multiplicand / dividend, two's complement
data_operandB  input  32  multiplier / divisor, two's complement
ctrl_MULT  input  1  start-multiply strobe, sampled at rising edge
ctrl_DIV  input  1  start-divide strobe, sampled at rising edge
data_result  output  32  low 32 bits of product, or quotient
data_exception  output  1  overflow / divide-by-zero flag, valid when data_resultRDY=1
data_resultRDY  output  1  one-cycle result-valid pulse
busy  output  1  high from capture edge until the result edge

Behaviour:
- Reset (asynchronous, any state): FSM returns to IDLE, counter=0. data_result=0, data_exception=0, data_resultRDY=0, busy=0. Reset aborts an operation in flight; no result is produced for it.
- States: IDLE, RUN, DONE.
- IDLE, ctrl_MULT=1 at an edge: enter RUN as multiply.
  - Capture |A| and |B|.
  - Capture result sign = A[31]^B[31].
  - Capture op type and flags: divzero=(B==0), divovf=(A==0x80000000 && B==0xFFFFFFFF).
  - counter=0, busy=1.
- IDLE, ctrl_DIV=1 at an edge: same capture as above, as divide.
- ctrl_MULT and ctrl_DIV both high in IDLE: multiply wins, divide is ignored.
- Strobes in RUN or DONE are ignored. No queuing.
- RUN: each edge performs one iteration and increments counter.
  - Multiply: add the multiplicand into the upper half when the LSB is 1, then shift right one place into the 64-bit accumulator.
  - Divide: shift left, trial-subtract the divisor from the upper half, and restore if negative. The quotient bit enters the LSB.
- At the edge that completes iteration 32: enter DONE and register the outputs.
  - Negate the magnitude result if sign=1.
  - data_resultRDY=1, busy=0.
- DONE lasts exactly one cycle. The next edge returns to IDLE and clears data_resultRDY. data_result holds its value until the next result or reset.
- A strobe present during the DONE cycle is ignored; the issuer must present it again in IDLE.
- Latency: data_resultRDY rises 32 edges after the capture edge and stays high for 1 cycle. Back-to-back throughput is one operation per 34 cycles.
- Multiply exception: 1 if the signed 64-bit product is outside [-2^31, 2^31-1]. data_result is still the low 32 bits of the true signed product.
- Divide: quotient truncates toward zero; the remainder is discarded.
- Divide exception cases:
  - divzero: data_result=0, exception=1. Full 32-cycle latency still applies.
  - divovf: data_result=0x80000000, exception=1.
- Zero operands give zero results with exception=0, except the divzero case.
- data_exception is 0 whenever data_resultRDY is 0.

Test Plan:
- Reset, then MULT with A=7, B=-3 (0xFFFFFFFD) -> data_resultRDY pulses for one cycle exactly 32 edges after capture; data_result=0xFFFFFFEB, exception=0, busy high for 32 cycles.
- MULT A=0x00010000, B=0x00010000 -> data_result=0x00000000, exception=1. Also MULT A=0x80000000, B=1 -> 0x80000000, exception=0.
- DIV A=-7 (0xFFFFFFF9), B=2 -> 0xFFFFFFFD (-3), exception=0. Also DIV A=100, B=-7 -> 0xFFFFFFF2 (-14).
- DIV A=5, B=0 -> data_result=0, exception=1 after 32 cycles. Also DIV A=0x80000000, B=0xFFFFFFFF -> 0x80000000, exception=1.
- Start MULT 3*4, assert ctrl_DIV at cycles 5 and 32 (DONE) -> both ignored; single RDY pulse with 12, then IDLE.
- Start DIV, assert reset at cycle 10 -> outputs 0 immediately, no RDY pulse. A new MULT 2*2 after release -> 4 at the normal latency.

Source files
------------

// File: rtl/multdiv_unit.sv
// Iterative 32-bit signed multiply / divide unit for the execute stage.
// Radix-2 shift-add multiplier and restoring divider on one 64-bit register.
module multdiv_unit #(
    parameter int WIDTH = 32,
    parameter int ITERS = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int CW = $clog2(ITERS + 1);
    localparam logic [CW-1:0] LAST = CW'(ITERS - 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   opnd_q;
    logic               neg_q;
    logic               is_div_q;
    logic               divzero_q;
    logic               divovf_q;
    logic [WIDTH-1:0]   result_q;
    logic               exc_q;
    logic               rdy_q;
    logic               busy_q;

    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               start_mul;
    logic               start_div;
    logic               divzero_d;
    logic               divovf_d;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH-1:0]   div_rem;
    logic [WIDTH:0]     div_diff;
    logic               div_qbit;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] acc_d;

    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH:0]     prod_top;
    logic               mul_ovf;
    logic [WIDTH-1:0]   quot_s;
    logic [WIDTH-1:0]   result_d;
    logic               exc_d;

    // Operand magnitudes and exception flags, sampled at the start edge.
    always_comb begin
        a_neg     = data_operandA[WIDTH-1];
        b_neg     = data_operandB[WIDTH-1];
        mag_a     = a_neg ? -data_operandA : data_operandA;
        mag_b     = b_neg ? -data_operandB : data_operandB;
        start_mul = ctrl_MULT;
        start_div = ctrl_DIV & ~ctrl_MULT;
        divzero_d = (data_operandB == '0);
        divovf_d  = (data_operandA == MIN_NEG) && (data_operandB == '1);
    end

    // One multiply or divide iteration on the shared working register.
    always_comb begin
        // Multiply: conditional add into the upper half, then shift right;
        // the carry out of the add becomes the new MSB.
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                 + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};

        // Divide: shift left, trial subtract, keep or restore the remainder.
        // The partial remainder stays below the divisor so it never needs
        // more than WIDTH bits after the shift.
        div_rem  = acc_q[2*WIDTH-2:WIDTH-1];
        div_diff = {1'b0, div_rem} - {1'b0, opnd_q};
        div_qbit = ~div_diff[WIDTH];
        div_next = {(div_qbit ? div_diff[WIDTH-1:0] : div_rem),
                    acc_q[WIDTH-2:0], div_qbit};

        acc_d    = is_div_q ? div_next : mul_next;
    end

    // Final sign fix-up and exception decode, applied on the last iteration.
    always_comb begin
        prod_s   = neg_q ? -mul_next : mul_next;
        prod_top = prod_s[2*WIDTH-1:WIDTH-1];
        mul_ovf  = ~((&prod_top) | ~(|prod_top));
        quot_s   = neg_q ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
        result_d = prod_s[WIDTH-1:0];
        exc_d    = mul_ovf;
        if (is_div_q) begin
            if (divzero_q) begin
                result_d = '0;
                exc_d    = 1'b1;
            end else if (divovf_q) begin
                result_d = MIN_NEG;
                exc_d    = 1'b1;
            end else begin
                result_d = quot_s;
                exc_d    = 1'b0;
            end
        end
    end

    // Control FSM with registered outputs; reset aborts any operation.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            neg_q     <= 1'b0;
            is_div_q  <= 1'b0;
            divzero_q <= 1'b0;
            divovf_q  <= 1'b0;
            result_q  <= '0;
            exc_q     <= 1'b0;
            rdy_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_mul || start_div) begin
                        state_q   <= RUN;
                        cnt_q     <= '0;
                        is_div_q  <= start_div;
                        neg_q     <= a_neg ^ b_neg;
                        acc_q     <= {{WIDTH{1'b0}},
                                      (start_div ? mag_a : mag_b)};
                        opnd_q    <= start_div ? mag_b : mag_a;
                        divzero_q <= divzero_d;
                        divovf_q  <= divovf_d;
                        busy_q    <= 1'b1;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_q  <= DONE;
                        result_q <= result_d;
                        exc_q    <= exc_d;
                        rdy_q    <= 1'b1;
                        busy_q   <= 1'b0;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    rdy_q   <= 1'b0;
                    exc_q   <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed + scoreboard bench for multdiv_unit.
// Expected results are queued at issue and popped on each result pulse.
module tb_multdiv_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int n_assert = 0;
    int n_fail = 0;
    logic [32:0] sb[$];

    multdiv_unit dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Independent reference using native signed arithmetic.
    function automatic logic [32:0] model(input bit mult,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint p;
        int q;
        logic [63:0] pv;
        logic e;
        if (mult) begin
            p = longint'(signed'(a)) * longint'(signed'(b));
            e = (p > 64'sd2147483647) || (p < -64'sd2147483648);
            pv = p;
            return {e, pv[31:0]};
        end
        if (b == 32'h0) return {1'b1, 32'h0};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return {1'b1, 32'h8000_0000};
        q = signed'(a) / signed'(b);
        return {1'b0, q};
    endfunction

    // Scoreboard: every result pulse must match the oldest queued entry.
    always @(negedge clock) begin
        if (data_resultRDY) begin
            chk("rdy_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                logic [32:0] e;
                e = sb.pop_front();
                chk("result", data_result, e[31:0]);
                chk("exception", 32'(data_exception), 32'(e[32]));
            end
        end
    end

    task automatic run_op(input bit mult, input logic [31:0] a,
                          input logic [31:0] b, input logic [32:0] exp,
                          input bit inject);
        int n;
        int nb;
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT = mult;
        ctrl_DIV = !mult;
        sb.push_back(exp);
        @(posedge clock);
        @(negedge clock);
        ctrl_MULT = 1'b0;
        ctrl_DIV = 1'b0;
        n = 0;
        nb = 0;
        while (n < 40) begin
            if (data_resultRDY) break;
            if (busy) nb++;
            if (inject) ctrl_DIV = (n == 4);
            @(posedge clock);
            n++;
            @(negedge clock);
        end
        chk("latency", 32'(n), 32'd32);
        chk("busy_cycles", 32'(nb), 32'd32);
        chk("busy_at_rdy", 32'(busy), 32'd0);
        if (inject) ctrl_DIV = 1'b1;
        @(negedge clock);
        ctrl_DIV = 1'b0;
        chk("rdy_one_cycle", 32'(data_resultRDY), 32'd0);
        chk("exc_low_idle", 32'(data_exception), 32'd0);
        chk("busy_after", 32'(busy), 32'd0);
        chk("result_hold", data_result, exp[31:0]);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        #2;
        chk("rst_result", data_result, 32'h0);
        chk("rst_rdy", 32'(data_resultRDY), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_exc", 32'(data_exception), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        run_op(1, 32'd7, 32'hFFFF_FFFD, {1'b0, 32'hFFFF_FFEB}, 0);
        run_op(1, 32'h0001_0000, 32'h0001_0000, {1'b1, 32'h0}, 0);
        run_op(1, 32'h8000_0000, 32'd1, {1'b0, 32'h8000_0000}, 0);
        run_op(0, 32'hFFFF_FFF9, 32'd2, {1'b0, 32'hFFFF_FFFD}, 0);
        run_op(0, 32'd100, 32'hFFFF_FFF9, {1'b0, 32'hFFFF_FFF2}, 0);
        run_op(0, 32'd5, 32'd0, {1'b1, 32'h0}, 0);
        run_op(0, 32'h8000_0000, 32'hFFFF_FFFF, {1'b1, 32'h8000_0000}, 0);
        run_op(1, 32'd0, 32'hFFFF_FFFF, {1'b0, 32'h0}, 0);
        run_op(0, 32'd0, 32'hFFFF_FFFF, {1'b0, 32'h0}, 0);

        // Both strobes together: multiply must win.
        @(negedge clock);
        data_operandA = 32'd6;
        data_operandB = 32'd5;
        ctrl_MULT = 1'b1;
        ctrl_DIV = 1'b1;
        sb.push_back({1'b0, 32'd30});
        @(negedge clock);
        ctrl_MULT = 1'b0;
        ctrl_DIV = 1'b0;
        repeat (34) @(negedge clock);
        chk("both_strobes_drained", 32'(sb.size()), 32'd0);

        // Divide strobes during RUN and DONE are ignored.
        run_op(1, 32'd3, 32'd4, {1'b0, 32'd12}, 1);
        repeat (40) @(negedge clock);
        chk("ignored_busy", 32'(busy), 32'd0);

        // Reset in the middle of a divide.
        @(negedge clock);
        data_operandA = 32'd1000;
        data_operandB = 32'd3;
        ctrl_DIV = 1'b1;
        @(negedge clock);
        ctrl_DIV = 1'b0;
        repeat (9) @(negedge clock);
        chk("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_result", data_result, 32'h0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_rdy", 32'(data_resultRDY), 32'd0);
        chk("abort_exc", 32'(data_exception), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        run_op(1, 32'd2, 32'd2, {1'b0, 32'd4}, 0);

        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i[0]) begin
                rb = $urandom_range(1, 1000);
                if (ra[5]) rb = -rb;
            end
            run_op(!i[0], ra, rb, model(!i[0], ra, rb), 0);
        end

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
